// File: rtl/regfile_pkg.sv
// Shared widths, requester indices and write-back payload type for the register-file write-back controller.
package regfile_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREGS  = 1 << ADDR_W;

   localparam logic REQ_MEM = 1'b0;
   localparam logic REQ_ALU = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // One-hot decode of a register address into a scoreboard-wide vector.
   function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
      reg_onehot = NREGS'(1) << a;
   endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry write-back holding register; reloads on the same edge it drains so a
// continuously granted requester sustains one write per cycle.
module wb_hold_slot
   import regfile_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    vld,
   input  wb_req_t req,
   input  logic    grant,
   output logic    rdy,
   output logic    full,
   output wb_req_t held
);

   logic    full_q;
   wb_req_t held_q;
   logic    take_c;

   // Ready is forced low while reset is asserted so nothing is accepted mid-reset.
   always_comb begin
      rdy    = rst_n & (~full_q | grant);
      take_c = vld & rdy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         held_q <= '0;
      end else if (take_c) begin
         full_q <= 1'b1;
         held_q <= req;
      end else if (grant) begin
         full_q <= 1'b0;
      end
   end

   assign full = full_q;
   assign held = held_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU/MEM slots onto the single write port
// and tracks pending writes for issue-stage RAW/WAW stalls. Macro WB_ARB_RR_EN selects round-robin.
module regfile_wb_ctrl
   import regfile_pkg::*;
(
   input  logic              CLK,
   input  logic              reset,
   input  logic              alu_vld,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_rdy,
   input  logic              mem_vld,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_rdy,
   output logic              rf_wr,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_din,
   input  logic              iss_vld,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   output logic              stall,
   output logic [NREGS-1:0]  busy_mask
);

   wb_req_t          alu_req, mem_req, alu_held, mem_held;
   logic             alu_full, mem_full;
   logic             alu_gnt, mem_gnt;
   logic             prio_mem;
   logic [NREGS-1:0] busy_q, busy_nxt, set_vec, clr_vec;

   assign alu_req = '{rd: alu_rd, data: alu_data};
   assign mem_req = '{rd: mem_rd, data: mem_data};

   wb_hold_slot u_mem_slot (
      .clk   (CLK),
      .rst_n (reset),
      .vld   (mem_vld),
      .req   (mem_req),
      .grant (mem_gnt),
      .rdy   (mem_rdy),
      .full  (mem_full),
      .held  (mem_held)
   );

   wb_hold_slot u_alu_slot (
      .clk   (CLK),
      .rst_n (reset),
      .vld   (alu_vld),
      .req   (alu_req),
      .grant (alu_gnt),
      .rdy   (alu_rdy),
      .full  (alu_full),
      .held  (alu_held)
   );

`ifdef WB_ARB_RR_EN
   logic last_q;

   // Pointer holds the last granted requester; reset value lets MEM win the first tie.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         last_q <= REQ_ALU;
      end else if (mem_gnt) begin
         last_q <= REQ_MEM;
      end else if (alu_gnt) begin
         last_q <= REQ_ALU;
      end
   end

   assign prio_mem = (last_q == REQ_ALU);
`else
   assign prio_mem = 1'b1;
`endif

   // Only the tie between two full slots consults the priority bit.
   always_comb begin
      mem_gnt = mem_full & (~alu_full | prio_mem);
      alu_gnt = alu_full & ~mem_gnt;
   end

   always_comb begin
      rf_wr  = 1'b0;
      rf_rd  = '0;
      rf_din = '0;
      if (mem_gnt) begin
         rf_wr  = (mem_held.rd != '0);
         rf_rd  = mem_held.rd;
         rf_din = mem_held.data;
      end else if (alu_gnt) begin
         rf_wr  = (alu_held.rd != '0);
         rf_rd  = alu_held.rd;
         rf_din = alu_held.data;
      end
   end

   // Scoreboard: set on a non-stalled issue, clear on a real write; set overrides clear.
   always_comb begin
      stall    = iss_vld & (busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[iss_rd]);
      set_vec  = '0;
      clr_vec  = '0;
      if (iss_vld && !stall && (iss_rd != '0)) begin
         set_vec = reg_onehot(iss_rd);
      end
      if (rf_wr) begin
         clr_vec = reg_onehot(rf_rd);
      end
      busy_nxt    = (busy_q & ~clr_vec) | set_vec;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   assign busy_mask = busy_q;

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller for the 32x32 register file (2 read ports, 1 write port, rd/wr/Din write interface). It shares the single write port between two requesters, ALU and MEM, using valid/ready handshakes and one-entry holding slots. It also keeps a per-register pending-write scoreboard that tells the issue stage when to stall on RAW/WAW hazards.

Parameters:
DATA_W, 32, write-data width
ADDR_W, 5, register address width
NREGS, 32, number of registers (2**ADDR_W); register 0 is hardwired zero

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
alu_vld  in  1  ALU write-back request valid
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_rdy  out  1  ALU slot can accept
mem_vld  in  1  MEM write-back request valid
mem_rd  in  ADDR_W  MEM destination register
mem_data  in  DATA_W  load data
mem_rdy  out  1  MEM slot can accept
rf_wr  out  1  register-file write enable
rf_rd  out  ADDR_W  register-file write address
rf_din  out  DATA_W  register-file write data
iss_vld  in  1  issue stage presents an instruction
iss_rd  in  ADDR_W  destination of issuing instruction
chk_rs1  in  ADDR_W  source 1 of issuing instruction
chk_rs2  in  ADDR_W  source 2 of issuing instruction
stall  out  1  issue must hold
busy_mask  out  NREGS  scoreboard state, bit r = write to r pending

Behaviour:
- Reset (reset=0, async): both slots empty, scoreboard all 0, RR pointer favours MEM. While reset is asserted: rf_wr=0, rf_rd=0, rf_din=0, stall=0, busy_mask=0, alu_rdy=mem_rdy=0. In-flight writes are discarded.
- Slot: each requester has one holding register {full, rd, data}. Accept on vld&rdy at a rising edge. rdy = ~full | grant_this_cycle (combinational), so a slot sustains 1 write/cycle when it is always granted.
- Arbitration (combinational from slot full bits): grant goes to one full slot. The default policy is fixed priority, MEM over ALU.
- Write port: rf_wr = granted slot full AND slot rd != 0. rf_rd and rf_din come from the granted slot; with no grant, rf_rd and rf_din are 0. The register file captures the write at the next edge, and the granted slot clears (or reloads) at that edge.
- Latency: request accepted at edge E0; rf_wr high during cycle E0..E1 if granted; RF updated at E1. A losing slot waits; its rdy stays 0.
- rd=0: request is accepted and granted normally, but rf_wr stays 0 and the scoreboard is untouched (silent drop).
- Scoreboard:
  - stall = iss_vld & (busy[chk_rs1] | busy[chk_rs2] | busy[iss_rd]); busy[0] is always 0.
  - On an edge with iss_vld & ~stall & iss_rd != 0: busy[iss_rd] is set.
  - On an edge with a granted write to r: busy[r] is cleared.
  - If set and clear hit the same r on the same edge, set wins.
- Write-back with busy[rd]=0 is legal (no underflow tracking).
- Both slots targeting the same rd: written in grant order; the last write wins in the RF.

Optional Feature:
WB_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last-grant pointer updates on every grant; when both slots are full, the one not granted last wins. The pointer resets to favour MEM.
- Undefined: fixed priority, MEM over ALU; no pointer flop exists, and ALU can be starved by back-to-back MEM traffic.

Decomposition:
- Shared package regfile_pkg: DATA_W, ADDR_W, NREGS constants; REQ_MEM=0 and REQ_ALU=1 index constants; a wb_req_t typedef {rd, data}.
- One natural sub-module, wb_hold_slot: one-entry holding register with vld/rdy/grant, instantiated twice.
- The arbiter and scoreboard stay in the top.

Test Plan:
1. Reset: reset=0 mid-stream with both slots full -> rf_wr=0 and busy_mask=0 immediately; after reset=1, alu_rdy=mem_rdy=1.
2. Single ALU write: iss rd=1 (busy_mask[1]=1), then alu rd=1 data=39 -> rf_wr=1, rf_rd=1, rf_din=39 for one cycle; busy_mask[1]=0 after that edge.
3. Collision: alu rd=4 data=11111 and mem rd=5 data=3 on the same edge -> MEM written first (rf_rd=5), ALU next cycle (rf_rd=4); alu_rdy=0 for the wait cycle.
4. Hazard: busy on rd=18; iss_vld with chk_rs1=18 -> stall=1 and no new busy bit set. After a write to 18 of value 1000 -> stall=0 the next cycle.
5. x0 and set/clear race:
   - mem rd=0 data=121 -> rf_wr stays 0 and mem_rdy recovers.
   - Issue rd=25 on the same edge as a write to 25 of value 267 -> busy_mask[25]=1.
6. With WB_ARB_RR_EN defined: both slots kept full for 4 cycles with rd=8/9 -> grants alternate MEM, ALU, MEM, ALU. Without it -> MEM on every cycle.
